// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply FSM states, counter width
// and the writeback out_sel encodings for mfhi/mflo.
package mips_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

    localparam logic [1:0] OUT_SEL_HI = 2'b11;
    localparam logic [1:0] OUT_SEL_LO = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mult_state_t;

endpackage

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: multiplicand register plus the
// combined accumulator/multiplier shift register.
module mult_shift_add
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] prod_o
);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH:0]     sum;

    // Extra adder bit keeps the carry that shifts into the top on each step
    always_comb begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d = {sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
        end else if (load_i) begin
            mcand_q <= mcand_i;
            acc_q   <= {{WIDTH{1'b0}}, mplier_i};
        end else if (step_i) begin
            acc_q   <= acc_d;
        end
    end

    assign prod_o = acc_q;

endmodule

// File: rtl/mult_unit.sv
// Iterative mult/multu unit: magnitude shift-add, sign-fix cycle,
// architectural HI/LO registers.
module mult_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mult_state_t        state_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] fix_prod;
    logic               accept;

    // Unsigned negation, so the most negative value maps to 2^(WIDTH-1)
    always_comb begin
        mag_a    = (sign && a[WIDTH-1]) ? -a : a;
        mag_b    = (sign && b[WIDTH-1]) ? -b : b;
        fix_prod = neg_q ? -prod : prod;
        accept   = (state_q == IDLE) && start;
    end

    mult_shift_add #(
        .WIDTH    (WIDTH)
    ) u_sa (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept),
        .step_i   (state_q == CALC),
        .mcand_i  (mag_a),
        .mplier_i (mag_b),
        .prod_o   (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        neg_q   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    {hi_q, lo_q} <= fix_prod;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit (WIDTH = 32).
module tb_mult_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int fails;

    mult_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op; returns at the negedge of the done cycle
    task automatic mult_op(input logic [31:0] av, input logic [31:0] bv,
                           input logic s, output int nbusy,
                           output bit got);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        sign  = s;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          nb;
        bit          got;
        int          bad;
        int          n;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sign  = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        mult_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, nb, got);
        check("u_max_done", 64'(got), 64'd1);
        check("u_max_nbusy", 64'(nb), 64'd33);
        check("u_max_busy0", 64'(busy), 64'd0);
        check("u_max_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);

        mult_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, nb, got);
        check("s_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        mult_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b0, nb, got);
        check("u_m3x7", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
        mult_op(32'h0000_0007, 32'hFFFF_FFFF, 1'b1, nb, got);
        check("s_7xm1", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF9);
        mult_op(32'hFFFF_FFFB, 32'h0000_0000, 1'b1, nb, got);
        check("s_m5x0", {hi, lo}, 64'd0);
        mult_op(32'h8000_0000, 32'h8000_0000, 1'b1, nb, got);
        check("s_min2", {hi, lo}, 64'h4000_0000_0000_0000);

        // HI/LO hold during busy, mid-busy start ignored
        hold_hi = hi;
        hold_lo = lo;
        @(negedge clk);
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        sign  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        bad   = 0;
        n     = 0;
        got   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (hi !== hold_hi || lo !== hold_lo) bad++;
            n++;
            if (n == 10) begin
                start = 1'b1;
                a     = 32'd4;
                b     = 32'd5;
                sign  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("hold_done", 64'(got), 64'd1);
        check("hold_cycles", 64'(n), 64'd33);
        check("hold_hilo", 64'(bad), 64'd0);
        check("hold_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // Back-to-back issue in the done cycle
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd3;
        sign  = 1'b0;
        n     = 0;
        got   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("b2b_done", 64'(got), 64'd1);
        check("b2b_lat", 64'(n), 64'd34);
        check("b2b_prod", {hi, lo}, 64'd6);

        // Asynchronous reset in the middle of CALC
        mult_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, nb, got);
        check("pre_rst_prod", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        @(negedge clk);
        start = 1'b1;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_busy", 64'(busy), 64'd0);
        mult_op(32'd4, 32'd5, 1'b0, nb, got);
        check("post_rst_done", 64'(got), 64'd1);
        check("post_rst_prod", {hi, lo}, 64'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
